// File: rtl/multicycle_ctrl.sv
// Control FSM for the multi-cycle RISC-V core: fetch/decode/execute/mem/writeback sequencing.
// Optional MULTICYCLE_TRAP_EN: illegal instructions halt in TRAP instead of retiring as NOPs.
module multicycle_ctrl #(
  parameter int INSTRET_W    = 32,
  parameter int MEM_WAIT_MAX = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 mem_ready,
  input  logic                 branch_taken,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic                 pc_sel,
  output logic                 rf_we,
  output logic [1:0]           wb_sel,
  output logic [3:0]           alu_func,
  output logic [1:0]           alu_src,
  output logic [2:0]           state,
  output logic [INSTRET_W-1:0] instret,
  output logic                 bus_err,
  output logic                 trap
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;

  localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 1);

  logic [2:0]           state_q, state_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;
  logic                 bus_err_q, bus_err_d;
  logic [WAIT_W-1:0]    wait_q, wait_d;
  logic                 retire;

  logic is_r, is_i, is_load, is_store, is_lui, is_jal, is_branch, f3_ok, legal;
  logic [3:0] dec_func;
  logic [1:0] dec_src;

  always_comb begin
    is_r      = (opcode == 7'b0110011);
    is_i      = (opcode == 7'b0010011);
    is_load   = (opcode == 7'b0000011);
    is_store  = (opcode == 7'b0100011);
    is_lui    = (opcode == 7'b0110111);
    is_jal    = (opcode == 7'b1101111);
    is_branch = (opcode == 7'b1100011);
    f3_ok     = (funct3 == 3'b000) || (funct3 == 3'b110) || (funct3 == 3'b111);
    legal     = ((is_r || is_i) && f3_ok) || is_load || is_store || is_lui || is_jal || is_branch;

    dec_func = 4'd0;
    dec_src  = 2'b00;
    if (is_r || is_i) begin
      case (funct3)
        3'b110:  dec_func = 4'd6;
        3'b111:  dec_func = 4'd7;
        default: dec_func = is_i ? 4'd1 : 4'd0;
      endcase
      dec_src = is_i ? 2'b10 : 2'b00;
    end else if (is_load) begin
      dec_func = 4'd2;
      dec_src  = 2'b10;
    end else if (is_store) begin
      dec_func = 4'd3;
      dec_src  = 2'b10;
    end else if (is_lui) begin
      dec_func = 4'd4;
      dec_src  = 2'b01;
    end else if (is_jal) begin
      dec_func = 4'd5;
      dec_src  = 2'b10;
    end else if (is_branch) begin
      dec_func = 4'd8;
      dec_src  = 2'b00;
    end
  end

  always_comb begin
    state_d  = state_q;
    retire   = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = 1'b0;
    rf_we    = 1'b0;
    wb_sel   = 2'b00;
    alu_func = 4'd0;
    alu_src  = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (legal) begin
          state_d = S_EXEC;
        end else begin
`ifdef MULTICYCLE_TRAP_EN
          state_d = S_TRAP;
`else
          pc_we   = 1'b1;
          retire  = 1'b1;
          state_d = S_FETCH;
`endif
        end
      end
      S_EXEC: begin
        alu_func = dec_func;
        alu_src  = dec_src;
        if (is_load || is_store) begin
          state_d = S_MEM;
        end else if (is_branch) begin
          pc_we   = 1'b1;
          pc_sel  = branch_taken;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else begin
          pc_we   = is_jal;
          pc_sel  = is_jal;
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_req  = 1'b1;
        mem_we   = is_store;
        alu_func = dec_func;
        alu_src  = dec_src;
        if (mem_ready) begin
          if (is_store) begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        wb_sel  = is_load ? 2'b01 : (is_jal ? 2'b10 : 2'b00);
        // JAL already redirected the PC in EXEC
        pc_we   = !is_jal;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP: begin
`ifdef MULTICYCLE_TRAP_EN
        state_d = S_TRAP;
`else
        state_d = S_FETCH;
`endif
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Timeout only raises the sticky flag; the request keeps retrying.
  always_comb begin
    wait_d    = wait_q;
    bus_err_d = bus_err_q;
    instret_d = retire ? instret_q + INSTRET_W'(1) : instret_q;
    if (!mem_req || mem_ready || (state_d != state_q)) begin
      wait_d = '0;
    end else if (wait_q == WAIT_W'(MEM_WAIT_MAX - 1)) begin
      wait_d    = '0;
      bus_err_d = 1'b1;
    end else begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
      bus_err_q <= 1'b0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
      bus_err_q <= bus_err_d;
      wait_q    <= wait_d;
    end
  end

  assign state   = state_q;
  assign instret = instret_q;
  assign bus_err = bus_err_q;
`ifdef MULTICYCLE_TRAP_EN
  assign trap    = (state_q == S_TRAP);
`else
  assign trap    = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl; stimulus driven on falling edges.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        mem_ready;
  logic        branch_taken;
  logic        mem_req, mem_we, ir_we, pc_we, pc_sel, rf_we;
  logic [1:0]  wb_sel;
  logic [3:0]  alu_func;
  logic [1:0]  alu_src;
  logic [2:0]  state;
  logic [31:0] instret;
  logic        bus_err;
  logic        trap;

  // {state, mem_req, mem_we, ir_we, pc_we, pc_sel, rf_we, wb_sel, alu_func, alu_src}
  logic [16:0] ctl;
  logic [16:0] exp_ctl;
  logic [31:0] exp_instret;
  int n_cmp = 0;
  int n_err = 0;

  assign ctl = {state, mem_req, mem_we, ir_we, pc_we, pc_sel, rf_we, wb_sel, alu_func, alu_src};

  always #5 clk = ~clk;

  multicycle_ctrl #(.INSTRET_W(32), .MEM_WAIT_MAX(16)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
    .mem_ready(mem_ready), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we), .pc_we(pc_we),
    .pc_sel(pc_sel), .rf_we(rf_we), .wb_sel(wb_sel), .alu_func(alu_func),
    .alu_src(alu_src), .state(state), .instret(instret), .bus_err(bus_err),
    .trap(trap)
  );

  task test_reset;
    rst_n = 1'b0; opcode = 7'd0; funct3 = 3'd0; mem_ready = 1'b0; branch_taken = 1'b0;
    exp_instret = 32'd0;
    @(negedge clk); #1;
    n_cmp++; exp_ctl = {3'd0, 6'b100000, 2'b00, 4'd0, 2'b00};
    if (ctl !== exp_ctl) begin n_err++; $display("FAIL reset_ctl got=%b exp=%b", ctl, exp_ctl); end
    n_cmp++;
    if ({instret, bus_err, trap} !== {32'd0, 1'b0, 1'b0}) begin n_err++; $display("FAIL reset_regs got instret=%0d bus_err=%b trap=%b exp 0/0/0", instret, bus_err, trap); end
    @(negedge clk); rst_n = 1'b1;
    $display("reset released at %0t", $time);
  endtask

  task test_add;
    @(negedge clk); opcode = 7'b0110011; funct3 = 3'b000; mem_ready = 1'b1; #1;
    n_cmp++; exp_ctl = {3'd0, 6'b101000, 2'b00, 4'd0, 2'b00};
    if (ctl !== exp_ctl) begin n_err++; $display("FAIL add_fetch got=%b exp=%b", ctl, exp_ctl); end
    @(negedge clk); #1;
    n_cmp++; exp_ctl = {3'd1, 6'b000000, 2'b00, 4'd0, 2'b00};
    if (ctl !== exp_ctl) begin n_err++; $display("FAIL add_decode got=%b exp=%b", ctl, exp_ctl); end
    @(negedge clk); #1;
    n_cmp++; exp_ctl = {3'd2, 6'b000000, 2'b00, 4'd0, 2'b00};
    if (ctl !== exp_ctl) begin n_err++; $display("FAIL add_exec got=%b exp=%b", ctl, exp_ctl); end
    @(negedge clk); #1;
    n_cmp++; exp_ctl = {3'd4, 6'b000101, 2'b00, 4'd0, 2'b00};
    if (ctl !== exp_ctl) begin n_err++; $display("FAIL add_wb got=%b exp=%b", ctl, exp_ctl); end
    n_cmp++;
    if (instret !== 32'd0) begin n_err++; $display("FAIL add_instret_early got=%0d exp=0", instret); end
    @(negedge clk); mem_ready = 1'b0; #1;
    exp_instret = 32'd1;
    n_cmp++;
    if ({state, instret} !== {3'd0, exp_instret}) begin n_err++; $display("FAIL add_retire got state=%0d instret=%0d exp 0/%0d", state, instret, exp_instret); end
    $display("ADD done instret=%0d", instret);
  endtask

  task test_load_wait;
    @(negedge clk); opcode = 7'b0000011; funct3 = 3'b010; mem_ready = 1'b1; #1;
    n_cmp++; exp_ctl = {3'd0, 6'b101000, 2'b00, 4'd0, 2'b00};
    if (ctl !== exp_ctl) begin n_err++; $display("FAIL lw_fetch got=%b exp=%b", ctl, exp_ctl); end
    @(negedge clk); @(negedge clk); #1;
    n_cmp++; exp_ctl = {3'd2, 6'b000000, 2'b00, 4'd2, 2'b10};
    if (ctl !== exp_ctl) begin n_err++; $display("FAIL lw_exec got=%b exp=%b", ctl, exp_ctl); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); mem_ready = (i == 3); #1;
      n_cmp++; exp_ctl = {3'd3, 6'b100000, 2'b00, 4'd2, 2'b10};
      if (ctl !== exp_ctl) begin n_err++; $display("FAIL lw_mem%0d got=%b exp=%b", i, ctl, exp_ctl); end
    end
    @(negedge clk); #1;
    n_cmp++; exp_ctl = {3'd4, 6'b000101, 2'b01, 4'd0, 2'b00};
    if (ctl !== exp_ctl) begin n_err++; $display("FAIL lw_wb got=%b exp=%b", ctl, exp_ctl); end
    @(negedge clk); mem_ready = 1'b0; #1;
    exp_instret = 32'd2;
    n_cmp++;
    if ({state, instret, bus_err} !== {3'd0, exp_instret, 1'b0}) begin n_err++; $display("FAIL lw_retire got state=%0d instret=%0d bus_err=%b exp 0/%0d/0", state, instret, bus_err, exp_instret); end
    $display("LW done instret=%0d", instret);
  endtask

  task test_branch;
    for (int t = 1; t >= 0; t--) begin
      @(negedge clk); opcode = 7'b1100011; funct3 = 3'b000; branch_taken = t[0]; mem_ready = 1'b1; #1;
      n_cmp++; exp_ctl = {3'd0, 6'b101000, 2'b00, 4'd0, 2'b00};
      if (ctl !== exp_ctl) begin n_err++; $display("FAIL beq%0d_fetch got=%b exp=%b", t, ctl, exp_ctl); end
      @(negedge clk); @(negedge clk); #1;
      n_cmp++; exp_ctl = {3'd2, 4'b0001, t[0], 1'b0, 2'b00, 4'd8, 2'b00};
      if (ctl !== exp_ctl) begin n_err++; $display("FAIL beq%0d_exec got=%b exp=%b", t, ctl, exp_ctl); end
      @(negedge clk); mem_ready = 1'b0; #1;
      exp_instret = exp_instret + 32'd1;
      n_cmp++;
      if ({state, instret} !== {3'd0, exp_instret}) begin n_err++; $display("FAIL beq%0d_retire got state=%0d instret=%0d exp 0/%0d", t, state, instret, exp_instret); end
      $display("BEQ taken=%0d done instret=%0d", t, instret);
    end
    branch_taken = 1'b0;
  endtask

  task test_fetch_timeout;
    opcode = 7'b0110111; funct3 = 3'b000;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk); #1;
      n_cmp++;
      if ({bus_err, mem_req, state} !== {1'b0, 1'b1, 3'd0}) begin n_err++; $display("FAIL timeout_wait%0d got bus_err=%b mem_req=%b state=%0d exp 0/1/0", i, bus_err, mem_req, state); end
    end
    @(negedge clk); #1;
    n_cmp++;
    if ({bus_err, mem_req, state} !== {1'b1, 1'b1, 3'd0}) begin n_err++; $display("FAIL timeout_hit got bus_err=%b mem_req=%b state=%0d exp 1/1/0", bus_err, mem_req, state); end
    @(negedge clk); mem_ready = 1'b1; #1;
    n_cmp++; exp_ctl = {3'd0, 6'b101000, 2'b00, 4'd0, 2'b00};
    if (ctl !== exp_ctl) begin n_err++; $display("FAIL timeout_fetch got=%b exp=%b", ctl, exp_ctl); end
    @(negedge clk); @(negedge clk); #1;
    n_cmp++; exp_ctl = {3'd2, 6'b000000, 2'b00, 4'd4, 2'b01};
    if (ctl !== exp_ctl) begin n_err++; $display("FAIL lui_exec got=%b exp=%b", ctl, exp_ctl); end
    @(negedge clk); #1;
    n_cmp++; exp_ctl = {3'd4, 6'b000101, 2'b00, 4'd0, 2'b00};
    if (ctl !== exp_ctl) begin n_err++; $display("FAIL lui_wb got=%b exp=%b", ctl, exp_ctl); end
    @(negedge clk); mem_ready = 1'b0; #1;
    exp_instret = exp_instret + 32'd1;
    n_cmp++;
    if ({state, instret, bus_err} !== {3'd0, exp_instret, 1'b1}) begin n_err++; $display("FAIL lui_retire got state=%0d instret=%0d bus_err=%b exp 0/%0d/1", state, instret, bus_err, exp_instret); end
    $display("timeout+LUI done instret=%0d bus_err=%b", instret, bus_err);
  endtask

  task test_alu_ops;
    logic [6:0]  op_t   [3];
    logic [2:0]  f3_t   [3];
    logic [16:0] exec_t [3];
    logic [16:0] wb_t   [3];
    op_t[0] = 7'b0010011; f3_t[0] = 3'b110;
    exec_t[0] = {3'd2, 6'b000000, 2'b00, 4'd6, 2'b10}; wb_t[0] = {3'd4, 6'b000101, 2'b00, 4'd0, 2'b00};
    op_t[1] = 7'b1101111; f3_t[1] = 3'b000;
    exec_t[1] = {3'd2, 6'b000110, 2'b00, 4'd5, 2'b10}; wb_t[1] = {3'd4, 6'b000001, 2'b10, 4'd0, 2'b00};
    op_t[2] = 7'b0110011; f3_t[2] = 3'b111;
    exec_t[2] = {3'd2, 6'b000000, 2'b00, 4'd7, 2'b00}; wb_t[2] = {3'd4, 6'b000101, 2'b00, 4'd0, 2'b00};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); opcode = op_t[k]; funct3 = f3_t[k]; mem_ready = 1'b1;
      @(negedge clk); @(negedge clk); #1;
      n_cmp++;
      if (ctl !== exec_t[k]) begin n_err++; $display("FAIL op%0d_exec got=%b exp=%b", k, ctl, exec_t[k]); end
      @(negedge clk); #1;
      n_cmp++;
      if (ctl !== wb_t[k]) begin n_err++; $display("FAIL op%0d_wb got=%b exp=%b", k, ctl, wb_t[k]); end
      @(negedge clk); mem_ready = 1'b0; #1;
      exp_instret = exp_instret + 32'd1;
      n_cmp++;
      if ({state, instret} !== {3'd0, exp_instret}) begin n_err++; $display("FAIL op%0d_retire got state=%0d instret=%0d exp 0/%0d", k, state, instret, exp_instret); end
      $display("op %b/%b done instret=%0d", op_t[k], f3_t[k], instret);
    end
  endtask

  task test_reset_mid;
    @(negedge clk); opcode = 7'b0100011; funct3 = 3'b010; mem_ready = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    n_cmp++; exp_ctl = {3'd2, 6'b000000, 2'b00, 4'd3, 2'b10};
    if (ctl !== exp_ctl) begin n_err++; $display("FAIL sw_exec got=%b exp=%b", ctl, exp_ctl); end
    @(negedge clk); mem_ready = 1'b0; #1;
    n_cmp++; exp_ctl = {3'd3, 6'b110000, 2'b00, 4'd3, 2'b10};
    if (ctl !== exp_ctl) begin n_err++; $display("FAIL sw_mem got=%b exp=%b", ctl, exp_ctl); end
    #2 rst_n = 1'b0; #1;
    exp_instret = 32'd0;
    n_cmp++;
    if ({state, mem_req, pc_we, instret, bus_err} !== {3'd0, 1'b1, 1'b0, exp_instret, 1'b0}) begin n_err++; $display("FAIL midrst_async got state=%0d mem_req=%b pc_we=%b instret=%0d bus_err=%b exp 0/1/0/0/0", state, mem_req, pc_we, instret, bus_err); end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_cmp++;
      if ({state, mem_req, pc_we, rf_we, instret} !== {3'd0, 1'b1, 1'b0, 1'b0, exp_instret}) begin n_err++; $display("FAIL midrst_after%0d got state=%0d mem_req=%b pc_we=%b rf_we=%b instret=%0d exp 0/1/0/0/0", i, state, mem_req, pc_we, rf_we, instret); end
    end
    $display("mid-instruction reset done instret=%0d", instret);
  endtask

  task test_illegal;
    @(negedge clk); opcode = 7'b0000000; funct3 = 3'b000; mem_ready = 1'b1;
    @(negedge clk); #1;
`ifdef MULTICYCLE_TRAP_EN
    n_cmp++; exp_ctl = {3'd1, 6'b000000, 2'b00, 4'd0, 2'b00};
    if (ctl !== exp_ctl) begin n_err++; $display("FAIL ill_decode got=%b exp=%b", ctl, exp_ctl); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      n_cmp++; exp_ctl = {3'd5, 6'b000000, 2'b00, 4'd0, 2'b00};
      if ({ctl, trap, instret} !== {exp_ctl, 1'b1, exp_instret}) begin n_err++; $display("FAIL ill_trap%0d got ctl=%b trap=%b instret=%0d exp ctl=%b trap=1 instret=%0d", i, ctl, trap, instret, exp_ctl, exp_instret); end
    end
`else
    n_cmp++; exp_ctl = {3'd1, 6'b000100, 2'b00, 4'd0, 2'b00};
    if (ctl !== exp_ctl) begin n_err++; $display("FAIL ill_decode got=%b exp=%b", ctl, exp_ctl); end
    @(negedge clk); mem_ready = 1'b0; #1;
    exp_instret = exp_instret + 32'd1;
    n_cmp++;
    if ({state, trap, instret} !== {3'd0, 1'b0, exp_instret}) begin n_err++; $display("FAIL ill_nop got state=%0d trap=%b instret=%0d exp 0/0/%0d", state, trap, instret, exp_instret); end
`endif
    $display("illegal opcode done state=%0d trap=%b instret=%0d", state, trap, instret);
  endtask

  initial begin
    test_reset;
    test_add;
    test_load_wait;
    test_branch;
    test_fetch_timeout;
    test_alu_ops;
    test_reset_mid;
    test_illegal;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
